multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Control sequencer for the multicycle RISC-V core: replaces the one-shot opcode decode with a
//  state machine that reuses one ALU and one unified memory across FETCH/DECODE/EXECUTE/MEM/WB.
//  Drives datapath mux selects and write enables each cycle. ALUOp goes to the existing ALU decoder.
//  A mem_ready handshake stalls the memory states.
// PARAMETERS
//  (none; encodings live in the shared package)
// PORTS
//  clk        in   1  core clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  op         in   7  opcode from instruction register (IR[6:0]), stable after FETCH
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory access completes this cycle
//  pc_write   out  1  PC register enable = pc_update | (branch & zero)
//  adr_src    out  1  memory address: 0=PC, 1=Result
//  mem_write  out  1  data memory write enable
//  ir_write   out  1  instruction register / OldPC enable
//  result_src out  2  00=ALUOut, 01=MemData, 10=ALUResult
//  alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1
//  alu_src_b  out  2  00=RD2, 01=ImmExt, 10=constant 4
//  imm_src    out  2  00=I, 01=S, 10=B, 11=J; combinational from op in every state
//  alu_op     out  2  00=add, 01=sub/compare, 10=funct-decoded
//  reg_write  out  1  register file write enable
//  illegal_op out  1  one-cycle pulse in DECODE for an unsupported opcode
//  state_dbg  out  4  current state encoding
// BEHAVIOUR
//  - Reset: state=FETCH. While rst_n=0, every enable (pc_write, mem_write, ir_write, reg_write) and
//    illegal_op is 0. Selects take their FETCH values. A reset mid-instruction aborts it with no writes.
//  - Outputs are Moore decodes of state, except: pc_write uses zero; FETCH enables and MEMWRITE
//    mem_write are qualified by mem_ready. Unlisted outputs are 0.
//  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready.
//    Stays in FETCH until mem_ready=1, then goes to DECODE.
//  - DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 1100011 -> BEQ.
//    Any other op -> FETCH with illegal_op=1.
//  - MEMADR: a=10, b=01, alu_op=00. op=0000011 -> MEMREAD, else MEMWRITE.
//  - MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then -> MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: adr_src=1, result_src=00, mem_write=mem_ready. Hold until mem_ready, then -> FETCH.
//    mem_write asserts exactly once.
//  - EXECUTER: a=10, b=00, alu_op=10 -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1; pc_write=zero -> FETCH.
//  - Cycles per instruction with mem_ready=1: lw 5, sw 4, R 4, beq 3. Each mem_ready=0 cycle adds 1.
//  - Unreachable state encodings recover to FETCH.
// CONFIGURATION
//  MULTICYCLE_ITYPE_JAL_EN defined:
//  - DECODE maps op=0010011 -> EXECUTEI (a=10, b=01, alu_op=10 -> ALUWB).
//  - DECODE maps op=1101111 -> JAL (a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB).
//    ALUWB then writes PC+4 to rd; the PC takes the target.
//  Undefined: both opcodes are illegal (DECODE -> FETCH, illegal_op=1). State encodings are unchanged.
// STRUCTURE
//  - Shared package rv_ctrl_pkg: opcode localparams, 4-bit state encodings, result_src/alu_src/imm_src/
//    alu_op encodings. The existing decoders use the same package.
//  - One sub-module, imm_src_decoder (op -> imm_src). FSM and output decode stay in this module.
// TESTING
//  - Reset then lw (op=0000011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB;
//    reg_write=1 only in cycle 5.
//  - sw, mem_ready=0 for 2 MEMWRITE cycles -> mem_write=1 for exactly 1 cycle, total 6 cycles.
//  - beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; back in FETCH next cycle either way.
//  - op=1111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH. No write enable asserted.
//  - rst_n low during MEMREAD -> outputs drop immediately; after release, state_dbg=FETCH, no reg_write.
//  - With MULTICYCLE_ITYPE_JAL_EN, jal -> FETCH,DECODE,JAL(pc_write=1),ALUWB(reg_write=1);
//    without it, illegal_op=1.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V core: opcodes, FSM states and datapath selects.
// Used by multicycle_control_fsm, imm_src_decoder and the existing ALU/main decoders.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Encodings are fixed regardless of which optional instructions are built in
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate format select from the opcode; purely combinational, valid in every FSM state.
module imm_src_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB over a shared ALU and unified memory.
// Optional I-type ALU and JAL support when MULTICYCLE_ITYPE_JAL_EN is defined.
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t state;
    state_t decode_next;
    logic   pc_update, branch, ir_en, mem_wr_en, reg_wr_en, illegal;

    always_comb begin
        decode_next = S_FETCH;
        case (op)
            OP_LOAD, OP_STORE: decode_next = S_MEMADR;
            OP_RTYPE:          decode_next = S_EXECUTER;
            OP_BRANCH:         decode_next = S_BEQ;
`ifdef MULTICYCLE_ITYPE_JAL_EN
            OP_ITYPE:          decode_next = S_EXECUTEI;
            OP_JAL:            decode_next = S_JAL;
`endif
            default:           decode_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_next;
                S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_JAL:      state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the registered state combinationally: pc_write follows zero and
    // the memory-state enables follow mem_ready within the same cycle.
    always_comb begin
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        mem_wr_en  = 1'b0;
        reg_wr_en  = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_en      = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                illegal   = (decode_next == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_wr_en  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_wr_en = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_ALUWB: reg_wr_en = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // State is already FETCH during reset; gating keeps FETCH's mem_ready-driven enables quiet too
    assign pc_write   = rst_n & (pc_update | (branch & zero));
    assign ir_write   = rst_n & ir_en;
    assign mem_write  = rst_n & mem_wr_en;
    assign reg_write  = rst_n & reg_wr_en;
    assign illegal_op = rst_n & illegal;
    assign state_dbg  = state;

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: instruction-plan model plus directed sequences.
// Honours MULTICYCLE_ITYPE_JAL_EN the same way as the design.
module tb_multicycle_control_fsm;
    import rv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [6:0] op;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
    logic [3:0] state_dbg;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_op(alu_op), .reg_write(reg_write),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Model: each instruction is FETCH, DECODE, then a fixed plan of phases chosen by opcode.
    // plan = {length, phase0, phase1, phase2}; length 0 means illegal.
    function automatic logic [15:0] plan_for(input logic [6:0] o);
        case (o)
            7'b0000011: return {4'd3, S_MEMADR, S_MEMREAD, S_MEMWB};
            7'b0100011: return {4'd2, S_MEMADR, S_MEMWRITE, 4'd0};
            7'b0110011: return {4'd2, S_EXECUTER, S_ALUWB, 4'd0};
            7'b1100011: return {4'd1, S_BEQ, 8'd0};
`ifdef MULTICYCLE_ITYPE_JAL_EN
            7'b0010011: return {4'd2, S_EXECUTEI, S_ALUWB, 4'd0};
            7'b1101111: return {4'd2, S_JAL, S_ALUWB, 4'd0};
`endif
            default:    return 16'd0;
        endcase
    endfunction

    function automatic logic [1:0] imm_for(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    state_t      m_phase;
    logic [7:0]  m_rest;
    logic [3:0]  m_cnt;
    logic [15:0] m_plan;
    assign m_plan = plan_for(op);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= S_FETCH;
            m_rest  <= '0;
            m_cnt   <= '0;
        end else if (!mem_ready && (m_phase == S_FETCH || m_phase == S_MEMREAD || m_phase == S_MEMWRITE)) begin
            m_phase <= m_phase;
        end else if (m_phase == S_FETCH) begin
            m_phase <= S_DECODE;
        end else if (m_phase == S_DECODE) begin
            if (m_plan[15:12] == 4'd0) begin
                m_phase <= S_FETCH;
            end else begin
                m_phase <= state_t'(m_plan[11:8]);
                m_rest  <= m_plan[7:0];
                m_cnt   <= m_plan[15:12] - 4'd1;
            end
        end else if (m_cnt != 4'd0) begin
            m_phase <= state_t'(m_rest[7:4]);
            m_rest  <= {m_rest[3:0], 4'h0};
            m_cnt   <= m_cnt - 4'd1;
        end else begin
            m_phase <= S_FETCH;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic       e_pcw, e_adr, e_mw, e_ir, e_rw, e_ill;
        logic [1:0] e_res, e_a, e_b, e_alu;
        {e_pcw, e_adr, e_mw, e_ir, e_rw, e_ill} = '0;
        {e_res, e_a, e_b, e_alu} = '0;
        case (m_phase)
            S_FETCH:    begin e_b = 2'b10; e_res = 2'b10; e_ir = mem_ready; e_pcw = mem_ready; end
            S_DECODE:   begin e_a = 2'b01; e_b = 2'b01; e_ill = (plan_for(op)[15:12] == 4'd0); end
            S_MEMADR:   begin e_a = 2'b10; e_b = 2'b01; end
            S_MEMREAD:  e_adr = 1'b1;
            S_MEMWB:    begin e_res = 2'b01; e_rw = 1'b1; end
            S_MEMWRITE: begin e_adr = 1'b1; e_mw = mem_ready; end
            S_EXECUTER: begin e_a = 2'b10; e_alu = 2'b10; end
            S_EXECUTEI: begin e_a = 2'b10; e_b = 2'b01; e_alu = 2'b10; end
            S_JAL:      begin e_a = 2'b01; e_b = 2'b10; e_pcw = 1'b1; end
            S_ALUWB:    e_rw = 1'b1;
            S_BEQ:      begin e_a = 2'b10; e_alu = 2'b01; e_pcw = zero; end
            default:    ;
        endcase
        if (!rst_n) {e_pcw, e_mw, e_ir, e_rw, e_ill} = '0;
        chk("cyc.state_dbg", state_dbg, m_phase);
        chk("cyc.pc_write", pc_write, e_pcw);
        chk("cyc.adr_src", adr_src, e_adr);
        chk("cyc.mem_write", mem_write, e_mw);
        chk("cyc.ir_write", ir_write, e_ir);
        chk("cyc.result_src", result_src, e_res);
        chk("cyc.alu_src_a", alu_src_a, e_a);
        chk("cyc.alu_src_b", alu_src_b, e_b);
        chk("cyc.imm_src", imm_src, imm_for(op));
        chk("cyc.alu_op", alu_op, e_alu);
        chk("cyc.reg_write", reg_write, e_rw);
        chk("cyc.illegal_op", illegal_op, e_ill);
    endtask

    // Per-cycle log of {illegal_op, pc_write, mem_write, reg_write, state_dbg}
    logic [7:0] tr[$];

    task automatic step(input logic mr);
        mem_ready = mr;
        @(negedge clk);
        check_cycle();
        if (rst_n) tr.push_back({illegal_op, pc_write, mem_write, reg_write, state_dbg});
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [6:0] o, input logic z, input logic [15:0] mrp, input int n);
        op   = o;
        zero = z;
        for (int i = 0; i < n; i++) step(mrp[i]);
    endtask

    // seq holds n state nibbles, first cycle in the most significant nibble
    task automatic pin_states(input string name, input int base, input logic [63:0] seq, input int n);
        chk({name, ".len"}, tr.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < tr.size()) chk(name, tr[base+i][3:0], seq[4*(n-1-i) +: 4]);
    endtask

    // bits holds n flags, first cycle in the most significant bit; pos selects the logged flag
    task automatic pin_bits(input string name, input int base, input logic [15:0] bits, input int n, input int pos);
        for (int i = 0; i < n; i++)
            if (base + i < tr.size()) chk(name, tr[base+i][pos], bits[n-1-i]);
    endtask

    int b;

    initial begin
        rst_n = 1'b0; op = 7'b0000011; zero = 1'b1; mem_ready = 1'b1;
        #1;
        chk("reset.state_dbg", state_dbg, 4'd0);
        chk("reset.ir_write", ir_write, 1'b0);
        chk("reset.pc_write", pc_write, 1'b0);
        @(posedge clk); #2;
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;

        b = tr.size(); run(7'b0000011, 1'b0, 16'hFFFF, 5);
        pin_states("lw.state", b, 64'h01234, 5);
        pin_bits("lw.reg_write", b, 16'b00001, 5, 4);
        pin_bits("lw.pc_write", b, 16'b10000, 5, 6);

        b = tr.size(); run(7'b0000011, 1'b0, 16'hFFF7, 6);
        pin_states("lw_stall.state", b, 64'h012334, 6);
        pin_bits("lw_stall.reg_write", b, 16'b000001, 6, 4);

        b = tr.size(); run(7'b0100011, 1'b0, 16'h0027, 6);
        pin_states("sw.state", b, 64'h012555, 6);
        pin_bits("sw.mem_write", b, 16'b000001, 6, 5);
        pin_bits("sw.reg_write", b, 16'b000000, 6, 4);

        b = tr.size(); run(7'b0110011, 1'b1, 16'h001E, 5);
        pin_states("rtype.state", b, 64'h00167, 5);
        pin_bits("rtype.reg_write", b, 16'b00001, 5, 4);
        pin_bits("rtype.pc_write", b, 16'b01000, 5, 6);

        b = tr.size(); run(7'b1100011, 1'b1, 16'hFFFF, 3);
        pin_states("beq_taken.state", b, 64'h01A, 3);
        pin_bits("beq_taken.pc_write", b, 16'b101, 3, 6);

        b = tr.size(); run(7'b1100011, 1'b0, 16'hFFFF, 3);
        pin_states("beq_not.state", b, 64'h01A, 3);
        pin_bits("beq_not.pc_write", b, 16'b100, 3, 6);

        b = tr.size(); run(7'b1111111, 1'b1, 16'hFFFF, 2);
        pin_states("illegal.state", b, 64'h01, 2);
        pin_bits("illegal.illegal_op", b, 16'b01, 2, 7);
        pin_bits("illegal.mem_write", b, 16'b00, 2, 5);
        pin_bits("illegal.reg_write", b, 16'b00, 2, 4);

`ifdef MULTICYCLE_ITYPE_JAL_EN
        b = tr.size(); run(7'b1101111, 1'b0, 16'hFFFF, 4);
        pin_states("jal.state", b, 64'h0197, 4);
        pin_bits("jal.pc_write", b, 16'b1010, 4, 6);
        pin_bits("jal.reg_write", b, 16'b0001, 4, 4);

        b = tr.size(); run(7'b0010011, 1'b0, 16'hFFFF, 4);
        pin_states("itype.state", b, 64'h0187, 4);
        pin_bits("itype.reg_write", b, 16'b0001, 4, 4);
`else
        b = tr.size(); run(7'b1101111, 1'b0, 16'hFFFF, 2);
        pin_states("jal.state", b, 64'h01, 2);
        pin_bits("jal.illegal_op", b, 16'b01, 2, 7);

        b = tr.size(); run(7'b0010011, 1'b0, 16'hFFFF, 2);
        pin_states("itype.state", b, 64'h01, 2);
        pin_bits("itype.illegal_op", b, 16'b01, 2, 7);
`endif

        // Abort a load in MEMREAD with an asynchronous reset
        run(7'b0000011, 1'b0, 16'hFFFF, 3);
        mem_ready = 1'b1;
        #1;
        chk("abort.pre_state", state_dbg, 4'd3);
        rst_n = 1'b0;
        #1;
        chk("abort.state_dbg", state_dbg, 4'd0);
        chk("abort.ir_write", ir_write, 1'b0);
        chk("abort.pc_write", pc_write, 1'b0);
        chk("abort.reg_write", reg_write, 1'b0);
        check_cycle();
        @(posedge clk); #2;
        step(1'b1);
        rst_n = 1'b1;
        b = tr.size(); step(1'b0); step(1'b0);
        pin_states("abort.after", b, 64'h00, 2);
        pin_bits("abort.reg_write", b, 16'b00, 2, 4);

        b = tr.size(); run(7'b0000011, 1'b0, 16'hFFFF, 5);
        pin_states("lw_after_abort.state", b, 64'h01234, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
